// File: rtl/fg_pkg.sv
// Shared types and widths for the function-generator control slice.
package fg_pkg;

  localparam int WAVE_W     = 2;
  localparam int STEP_IDX_W = 3;

  typedef enum logic [WAVE_W-1:0] {
    SINE     = 2'd0,
    SQUARE   = 2'd1,
    TRIANGLE = 2'd2,
    SAW      = 2'd3
  } wave_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/fg_ftw_stepper.sv
// Saturating FTW up/down step; combinational, wide intermediates avoid wrap.
module fg_ftw_stepper
  import fg_pkg::*;
#(
  parameter int                 PHASE_W   = 32,
  parameter int                 STEP_UNIT = 1000,
  parameter logic [PHASE_W-1:0] FTW_MIN   = PHASE_W'(1000),
  parameter logic [PHASE_W-1:0] FTW_MAX   = PHASE_W'(32'h4000_0000)
) (
  input  logic [PHASE_W-1:0]    ftw,
  input  logic [STEP_IDX_W-1:0] step_idx,
  input  logic                  up,
  input  logic                  down,
  output logic [PHASE_W-1:0]    ftw_next,
  output logic                  changed
);

  localparam int SUM_W  = PHASE_W + 8;
  localparam int DIFF_W = PHASE_W + 9;

  logic        [SUM_W-1:0]  step_w;
  logic        [SUM_W-1:0]  sum_w;
  logic signed [DIFF_W-1:0] diff_w;

  always_comb begin
    step_w   = SUM_W'(STEP_UNIT) << step_idx;
    sum_w    = {8'b0, ftw} + step_w;
    diff_w   = $signed({9'b0, ftw}) - $signed({1'b0, step_w});
    ftw_next = ftw;
    // Simultaneous up and down cancel out and leave the FTW untouched.
    if (up && !down) begin
      ftw_next = (sum_w > SUM_W'(FTW_MAX)) ? FTW_MAX : sum_w[PHASE_W-1:0];
    end else if (down && !up) begin
      ftw_next = (diff_w < $signed(DIFF_W'(FTW_MIN))) ? FTW_MIN : diff_w[PHASE_W-1:0];
    end
    changed = (ftw_next != ftw);
  end

endmodule

// File: rtl/fg_control.sv
// Turns button pulses into waveform/FTW working state and publishes
// snapshots to the DDS core over a valid/ready handshake.
module fg_control
  import fg_pkg::*;
#(
  parameter int                 PHASE_W      = 32,
  parameter int                 STEP_UNIT    = 1000,
  parameter int                 STEP_IDX_MAX = 7,
  parameter logic [PHASE_W-1:0] FTW_MIN      = PHASE_W'(1000),
  parameter logic [PHASE_W-1:0] FTW_MAX      = PHASE_W'(32'h4000_0000),
  parameter logic [PHASE_W-1:0] FTW_RESET    = PHASE_W'(100000)
) (
  input  logic                  Fg_clk,
  input  logic                  Reset,
  input  logic                  Btn_wave,
  input  logic                  Btn_step,
  input  logic                  Btn_up,
  input  logic                  Btn_down,
  output logic [STEP_IDX_W-1:0] Step_idx,
  output logic [WAVE_W-1:0]     Cfg_wave,
  output logic [PHASE_W-1:0]    Cfg_ftw,
  output logic                  Cfg_valid,
  input  logic                  Cfg_ready
);

  wave_e              wave_r;
  logic [PHASE_W-1:0] ftw_r;
  logic [PHASE_W-1:0] ftw_next;
  logic               ftw_changed;
  logic               dirty;
  logic               dirty_set;
  state_e             state;

  fg_ftw_stepper #(
    .PHASE_W   (PHASE_W),
    .STEP_UNIT (STEP_UNIT),
    .FTW_MIN   (FTW_MIN),
    .FTW_MAX   (FTW_MAX)
  ) u_stepper (
    .ftw      (ftw_r),
    .step_idx (Step_idx),
    .up       (Btn_up),
    .down     (Btn_down),
    .ftw_next (ftw_next),
    .changed  (ftw_changed)
  );

  assign dirty_set = Btn_wave | ftw_changed;

  always_ff @(posedge Fg_clk or posedge Reset) begin
    if (Reset) begin
      wave_r    <= SINE;
      ftw_r     <= FTW_RESET;
      Step_idx  <= '0;
      dirty     <= 1'b1;
      Cfg_wave  <= '0;
      Cfg_ftw   <= FTW_RESET;
      Cfg_valid <= 1'b0;
      state     <= IDLE;
    end else begin
      if (Btn_wave) begin
        wave_r <= wave_e'(wave_r + 1'b1);
      end
      if (Btn_step) begin
        Step_idx <= (Step_idx == STEP_IDX_W'(STEP_IDX_MAX)) ? '0 : Step_idx + 1'b1;
      end
      ftw_r <= ftw_next;
      dirty <= dirty | dirty_set;

      case (state)
        IDLE: begin
          // Capture takes pre-update working values; a press in this cycle
          // keeps dirty set so a follow-up snapshot is issued.
          if (dirty) begin
            Cfg_wave  <= wave_r;
            Cfg_ftw   <= ftw_r;
            Cfg_valid <= 1'b1;
            dirty     <= dirty_set;
            state     <= SEND;
          end
        end
        SEND: begin
          if (Cfg_ready) begin
            Cfg_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
